// File: rtl/ring_buff_drain.sv
// ring_buff_drain
// ---------------------------------------------------------------------------
// Read-side drain controller sitting directly after the ring buffer. It
// decides when to start draining (occupancy threshold, or a timeout for a
// partially filled buffer). It issues read-enables to the buffer and captures
// the combinationally presented read data into a 2-entry skid register. It
// forwards tokens to the next stage over a valid/nack link.
//
// Handshake: a token is transferred to the next stage in every cycle where
// O_Valid=1 and I_Nack=0. O_Valid/O_FTk come straight from registers.
// I_Nack never reaches O_Re combinationally; the skid's spare slot absorbs
// the one read already issued in the cycle the nack arrives.
//
// Ports:
//   clock      in   clock
//   reset      in   synchronous, active-high reset
//   I_Empty    in   buffer empty flag
//   I_Num      in   buffer occupancy (0..DEPTH_BUFF)
//   I_FTk      in   buffer read data, meaningful only while O_Re=1
//   O_Re       out  buffer read-enable
//   O_FTk      out  token to the next stage, '0 when O_Valid=0
//   O_Valid    out  O_FTk holds a token
//   I_Nack     in   next stage refuses the token this cycle
//   O_Busy     out  FSM not in IDLE, or skid not empty
//   dbg_state  out  FSM state (0=IDLE, 1=ACCUM, 2=DRAIN)
//   dbg_cnt    out  skid occupancy (0..2)
// ---------------------------------------------------------------------------
module ring_buff_drain #(
    // Token type of the attached buffer; the 8-bit default stands in for the
    // buffer's forward-token type when no override is given.
    parameter type TYPE_FWRD   = logic [7:0],
    parameter int  DEPTH_BUFF  = 16,
    parameter int  WIDTH_DEPTH = $clog2(DEPTH_BUFF),
    parameter int  THRESHOLD   = 4,
    parameter int  TIMEOUT     = 8,
    parameter int  WIDTH_TMO   = $clog2(TIMEOUT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             I_Empty,
    input  logic [WIDTH_DEPTH:0] I_Num,
    input  TYPE_FWRD         I_FTk,
    output logic             O_Re,
    output TYPE_FWRD         O_FTk,
    output logic             O_Valid,
    input  logic             I_Nack,
    output logic             O_Busy,
    output logic [1:0]       dbg_state,
    output logic [1:0]       dbg_cnt
);

    // TIMEOUT=0 gives a zero-width timer; keep at least one bit so the
    // register is always legal (it is simply never used in that case).
    localparam int TW = (WIDTH_TMO < 1) ? 1 : WIDTH_TMO;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [WIDTH_DEPTH:0] THR = (WIDTH_DEPTH + 1)'(THRESHOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [1:0]      cnt;
    TYPE_FWRD        s0;
    TYPE_FWRD        s1;

    logic            at_threshold;
    logic            accept;
    logic            load_s0;
    logic            load_s1;

    assign at_threshold = (I_Num >= THR);

    // ------------------------------------------------------------------
    // Drain-decision FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!I_Empty) begin
                        if (at_threshold || (TIMEOUT == 0)) begin
                            state <= DRAIN;
                        end else begin
                            state <= ACCUM;
                            timer <= '0;
                        end
                    end
                end
                ACCUM: begin
                    timer <= timer + 1'b1;
                    // Nothing reads while accumulating, so going empty here
                    // means the buffer was cleared behind our back.
                    if (I_Empty) begin
                        state <= IDLE;
                    end else if (at_threshold || (timer == TMO_LAST)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Keep draining until empty; late writes are drained too.
                    if (I_Empty) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read-enable and skid register
    // ------------------------------------------------------------------
    // Reading only while a skid slot is guaranteed free keeps I_Nack out of
    // this path: with cnt<2 there is always room for the token in flight.
    assign O_Re    = (state == DRAIN) && !I_Empty && (cnt < 2'd2);
    assign O_Valid = (cnt != 2'd0);
    assign accept  = O_Valid && !I_Nack;

    // A new token lands in S0 if S0 is empty or leaving this cycle,
    // otherwise it goes to the overflow slot S1.
    assign load_s0 = O_Re && ((cnt == 2'd0) || accept);
    assign load_s1 = O_Re && !load_s0;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= 2'd0;
            s0  <= '0;
            s1  <= '0;
        end else begin
            if (load_s0) begin
                s0 <= I_FTk;
            end else if (accept && (cnt == 2'd2)) begin
                s0 <= s1;
            end

            if (load_s1) begin
                s1 <= I_FTk;
            end

            // Read and accept together leave the occupancy unchanged.
            case ({O_Re, accept})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign O_FTk     = O_Valid ? s0 : TYPE_FWRD'('0);
    assign O_Busy    = (state != IDLE) || (cnt != 2'd0);
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule
